regfile_read_arbiter: RTL and testbench
=======================================

# regfile_read_arbiter

Shares one combinational read port of the KGPminiRISC register bank between the core datapath (priority requester) and a debug/display requester, such as the board-level LED display. The core wins by default. A starvation counter guarantees the debug side a slot. Debug reads use a req/ack handshake with registered data, so the display logic never has to reach hierarchically into `reg_bank`.

## Interface
Parameters:
- `ADDR_W`, default 5: register address width.
- `DATA_W`, default 32: register data width.
- `STARVE_MAX`, default 8: consecutive core-won cycles with debug pending before debug is forced in. Legal range 1..255.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `core_req`  in  1: core read request this cycle.
- `core_addr`  in  ADDR_W: core read address.
- `core_rdata`  out  DATA_W: `rf_rdata`, passed through combinationally.
- `core_stall`  out  1: core did not get the port this cycle.
- `dbg_req`  in  1: debug request, level. Held high until `dbg_ack`.
- `dbg_addr`  in  ADDR_W: debug address. Stable while `dbg_req` is high.
- `dbg_ack`  out  1: one-cycle pulse; `dbg_data` is valid.
- `dbg_data`  out  DATA_W: registered debug read result.
- `rf_raddr`  out  ADDR_W: to the register bank read address.
- `rf_rdata`  in  DATA_W: from the register bank, combinational read.
- `stat_dbg_grants`  out  16: count of debug slots granted. Zero unless `RF_ARB_STATS_EN` is defined.
- `stat_core_stalls`  out  16: count of core stall cycles. Zero unless `RF_ARB_STATS_EN` is defined.

## Operation
FSM states: `IDLE`, `ACK`, `DRAIN`.

Debug slot:
- Definition: `dbg_slot = (state==IDLE) & dbg_req & (~core_req | starve_cnt==STARVE_MAX) & ~rst`.
- Port mux: `rf_raddr = dbg_slot ? dbg_addr : core_addr`.
- `core_stall = core_req & dbg_slot`.

Transitions:
- `IDLE` → `ACK` on `dbg_slot`. On that edge `dbg_data <= rf_rdata`.
- `ACK`: `dbg_ack=1` for exactly one cycle, then → `DRAIN`.
- `DRAIN`: stays until `dbg_req==0`, then → `IDLE`. This prevents re-serving a request that is still high.
- In `ACK` and `DRAIN` the core owns the port unconditionally.

Starvation counter:
- Increments when `state==IDLE & dbg_req & core_req & ~dbg_slot`.
- Saturates at `STARVE_MAX`.
- Clears on `dbg_slot` and whenever `dbg_req==0`.

General rules:
- The core is never stalled when `dbg_req` is low.
- At most one debug slot per request.
- With continuous `core_req`, debug latency from `dbg_req` rise to slot is exactly `STARVE_MAX` cycles.
- Simultaneous `dbg_req` rise and `core_req` with `STARVE_MAX` reached cannot occur, because the counter is cleared while `dbg_req` is low.

## Timing
- Zero latency for the core: `core_rdata` and `core_stall` are valid in the same cycle as `core_req`.
- Debug, core idle:
  - `dbg_req` rises in cycle N, so the slot is in cycle N.
  - `dbg_ack` and `dbg_data` appear in cycle N+1.
  - The earliest next slot is the cycle after `dbg_req` is seen low in `DRAIN`.
- Reset values: `state=IDLE`, `starve_cnt=0`, `dbg_ack=0`, `dbg_data=0`, stats = 0.
- While `rst` is high: `core_stall=0` and `rf_raddr=core_addr`.
- Reset mid-handshake (in `ACK` or `DRAIN`) abandons the request. After reset the requester must re-present it; a still-high `dbg_req` is served again from `IDLE`.
- `dbg_addr` is used only in the slot cycle. Changes outside the slot are ignored.

## Configuration
Macro `RF_ARB_STATS_EN`.
- Defined:
  - `stat_dbg_grants` increments on each `dbg_slot`.
  - `stat_core_stalls` increments on each cycle with `core_stall==1`.
  - Both are 16-bit, saturate at 16'hFFFF, and reset to 0.
- Undefined: no counter logic is compiled; both outputs are tied to 16'h0000. Arbitration is identical either way.

## Structure
- Package `rf_arb_pkg`:
  - state enum (`IDLE`, `ACK`, `DRAIN`)
  - default `ADDR_W`/`DATA_W` constants
  - stats counter width constant (16)
- Sub-module `sat_counter`: parameterised width and max, with inc and clr inputs. Used once for the starvation counter and, under the macro, twice for the stats counters.

## Test plan
- Core idle, model `reg_bank[21]=32'h0000_BEEF`, `dbg_req=1`, `dbg_addr=21`.
  - Slot in the same cycle.
  - Next cycle: `dbg_ack=1`, `dbg_data=32'h0000_BEEF`.
  - Following cycle: `dbg_ack=0`.
- `core_req` held high, `STARVE_MAX=8`, `dbg_req` rises.
  - Exactly 8 cycles with `core_stall=0`, then 1 cycle with `core_stall=1` and `rf_raddr=dbg_addr`.
  - Then `dbg_ack`.
- Hold `dbg_req` high 5 cycles after `dbg_ack`: exactly one `dbg_ack`; state stays `DRAIN`; core is never stalled.
- Assert `rst` during `ACK`:
  - `dbg_ack=0`, `dbg_data=0` immediately.
  - With `dbg_req` still high and core idle, a new slot in the first cycle after reset release.
- Toggle `core_req` randomly for 1000 cycles with no `dbg_req`: `core_stall` stays 0; `rf_raddr` always equals `core_addr`.
- With `RF_ARB_STATS_EN`, run scenario 2 three times: `stat_dbg_grants=3`, `stat_core_stalls=3`. Without the macro both read 0.

Source files
------------

// File: rtl/rf_arb_pkg.sv
// Shared types and constants for the register-file read arbiter.
// Contents:
//   arb_state_e : arbiter FSM states (IDLE, ACK, DRAIN)
//   RF_ADDR_W   : default register address width
//   RF_DATA_W   : default register data width
//   STAT_W      : width of the optional statistics counters
package rf_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACK   = 2'd1,
    DRAIN = 2'd2
  } arb_state_e;

  localparam int unsigned RF_ADDR_W = 5;
  localparam int unsigned RF_DATA_W = 32;
  localparam int unsigned STAT_W    = 16;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Ports:
//   clk : clock, rising edge
//   rst : asynchronous active-high reset, counter -> 0
//   inc : count up by one unless already at MAX
//   clr : return to zero; takes priority over inc
//   cnt : current count
module sat_counter #(
  parameter int unsigned W   = 8,
  parameter logic [W-1:0] MAX = '1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/regfile_read_arbiter.sv
// Shares one combinational register-bank read port between the core
// (priority) and a debug requester (req/ack handshake, registered data).
// A starvation counter forces a debug slot after STARVE_MAX consecutive
// core-won cycles with debug pending.
//
// Ports:
//   clk, rst              : clock / asynchronous active-high reset
//   core_req, core_addr   : core read request and address
//   core_rdata            : rf_rdata passed straight through
//   core_stall            : core lost the port this cycle
//   dbg_req, dbg_addr     : debug level request and address
//   dbg_ack, dbg_data     : one-cycle ack with registered read data
//   rf_raddr, rf_rdata    : register bank read port
//   stat_dbg_grants       : debug slots granted (stats build only)
//   stat_core_stalls      : core stall cycles (stats build only)
//
// Build option: define RF_ARB_STATS_EN to compile the statistics
// counters; otherwise both stat outputs are tied to zero.
//
// state | meaning
// IDLE  | arbitrating; debug may take the slot this cycle
// ACK   | dbg_ack high, dbg_data valid
// DRAIN | waiting for dbg_req to drop so one request gets one slot
module regfile_read_arbiter
  import rf_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = RF_ADDR_W,
  parameter int unsigned DATA_W     = RF_DATA_W,
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_req,
  input  logic [ADDR_W-1:0] core_addr,
  output logic [DATA_W-1:0] core_rdata,
  output logic              core_stall,
  input  logic              dbg_req,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic              dbg_ack,
  output logic [DATA_W-1:0] dbg_data,
  output logic [ADDR_W-1:0] rf_raddr,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic [STAT_W-1:0] stat_dbg_grants,
  output logic [STAT_W-1:0] stat_core_stalls
);

  localparam logic [7:0] STARVE_MAX_C = STARVE_MAX[7:0];

  arb_state_e        state_q;
  logic              dbg_ack_q;
  logic [DATA_W-1:0] dbg_data_q;
  logic [7:0]        starve_cnt;
  logic              dbg_slot;
  logic              starve_inc;
  logic              starve_clr;

  // rst is folded in so the port stays with the core while reset is held.
  assign dbg_slot = (state_q == IDLE) && dbg_req && !rst &&
                    (!core_req || (starve_cnt == STARVE_MAX_C));

  assign rf_raddr   = dbg_slot ? dbg_addr : core_addr;
  assign core_rdata = rf_rdata;
  assign core_stall = core_req && dbg_slot;

  // Clearing while dbg_req is low means a fresh request always starts at 0.
  assign starve_inc = (state_q == IDLE) && dbg_req && core_req && !dbg_slot;
  assign starve_clr = dbg_slot || !dbg_req;

  sat_counter #(
    .W   (8),
    .MAX (STARVE_MAX_C)
  ) u_starve_cnt (
    .clk (clk),
    .rst (rst),
    .inc (starve_inc),
    .clr (starve_clr),
    .cnt (starve_cnt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      dbg_ack_q  <= 1'b0;
      dbg_data_q <= '0;
    end else begin
      dbg_ack_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (dbg_slot) begin
            state_q    <= ACK;
            dbg_ack_q  <= 1'b1;
            dbg_data_q <= rf_rdata;
          end
        end
        ACK: begin
          state_q <= DRAIN;
        end
        DRAIN: begin
          if (!dbg_req) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign dbg_ack  = dbg_ack_q;
  assign dbg_data = dbg_data_q;

`ifdef RF_ARB_STATS_EN
  sat_counter #(
    .W   (STAT_W),
    .MAX ({STAT_W{1'b1}})
  ) u_stat_grants (
    .clk (clk),
    .rst (rst),
    .inc (dbg_slot),
    .clr (1'b0),
    .cnt (stat_dbg_grants)
  );

  sat_counter #(
    .W   (STAT_W),
    .MAX ({STAT_W{1'b1}})
  ) u_stat_stalls (
    .clk (clk),
    .rst (rst),
    .inc (core_stall),
    .clr (1'b0),
    .cnt (stat_core_stalls)
  );
`else
  assign stat_dbg_grants  = '0;
  assign stat_core_stalls = '0;
`endif

endmodule

// File: tb/tb_regfile_read_arbiter.sv
module tb_regfile_read_arbiter;
  import rf_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        core_req;
  logic [4:0]  core_addr;
  logic [31:0] core_rdata;
  logic        core_stall;
  logic        dbg_req;
  logic [4:0]  dbg_addr;
  logic        dbg_ack;
  logic [31:0] dbg_data;
  logic [4:0]  rf_raddr;
  logic [31:0] rf_rdata;
  logic [15:0] stat_dbg_grants;
  logic [15:0] stat_core_stalls;

  logic [31:0] reg_bank [32];
  logic [31:0] exp_q [$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign rf_rdata = reg_bank[rf_raddr];

  regfile_read_arbiter dut (
    .clk              (clk),
    .rst              (rst),
    .core_req         (core_req),
    .core_addr        (core_addr),
    .core_rdata       (core_rdata),
    .core_stall       (core_stall),
    .dbg_req          (dbg_req),
    .dbg_addr         (dbg_addr),
    .dbg_ack          (dbg_ack),
    .dbg_data         (dbg_data),
    .rf_raddr         (rf_raddr),
    .rf_rdata         (rf_rdata),
    .stat_dbg_grants  (stat_dbg_grants),
    .stat_core_stalls (stat_core_stalls)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expect an ack this cycle and compare data against the scoreboard head.
  task automatic chk_ack(input string tag);
    logic [31:0] e;
    chk({tag, "_ack"}, 32'(dbg_ack), 32'd1);
    chk({tag, "_qlen"}, 32'(exp_q.size()), 32'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({tag, "_data"}, dbg_data, e);
    end
  endtask

  // Core requesting continuously while debug asks for addr; hold dbg_req
  // for 'hold' cycles after the ack, then drop it and return to IDLE.
  task automatic starve_run(input logic [4:0] caddr, input logic [4:0] daddr, input int hold);
    core_req  = 1'b1;
    core_addr = caddr;
    dbg_req   = 1'b1;
    dbg_addr  = daddr;
    #1;
    for (int i = 0; i < 8; i++) begin
      chk("starve_nostall", 32'(core_stall), 32'd0);
      chk("starve_raddr_core", 32'(rf_raddr), 32'(caddr));
      tick();
    end
    chk("starve_stall", 32'(core_stall), 32'd1);
    chk("starve_raddr_dbg", 32'(rf_raddr), 32'(daddr));
    exp_q.push_back(reg_bank[daddr]);
    tick();
    chk_ack("starve");
    chk("starve_ack_nostall", 32'(core_stall), 32'd0);
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("drain_noack", 32'(dbg_ack), 32'd0);
      chk("drain_nostall", 32'(core_stall), 32'd0);
      chk("drain_state", 32'(dut.state_q), 32'(DRAIN));
    end
    tick();
    dbg_req = 1'b0;
    tick();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) reg_bank[i] = 32'hA5000000 ^ (i * 32'h00010203);
    reg_bank[21] = 32'h0000_BEEF;

    rst = 1'b1;
    core_req = 1'b1;
    core_addr = 5'd7;
    dbg_req = 1'b1;
    dbg_addr = 5'd12;
    #2;
    chk("rst_stall", 32'(core_stall), 32'd0);
    chk("rst_raddr", 32'(rf_raddr), 32'd7);
    chk("rst_ack", 32'(dbg_ack), 32'd0);
    chk("rst_data", dbg_data, 32'd0);
    chk("rst_grants", 32'(stat_dbg_grants), 32'd0);
    chk("rst_stalls", 32'(stat_core_stalls), 32'd0);
    core_req = 1'b0;
    dbg_req = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Debug read with core idle: slot same cycle, ack next cycle.
    core_addr = 5'd2;
    dbg_req = 1'b1;
    dbg_addr = 5'd21;
    #1;
    chk("idle_slot_raddr", 32'(rf_raddr), 32'd21);
    chk("idle_slot_nostall", 32'(core_stall), 32'd0);
    exp_q.push_back(32'h0000_BEEF);
    tick();
    chk_ack("idle");
    tick();
    chk("idle_ack_low", 32'(dbg_ack), 32'd0);
    dbg_req = 1'b0;
    tick();
    tick();

    // Starvation with one-cycle drain, then with a 5-cycle held request.
    starve_run(5'd3, 5'd10, 0);
    starve_run(5'd4, 5'd17, 5);

    // Reset during ACK abandons the handshake; still-high request re-served.
    core_req = 1'b0;
    core_addr = 5'd9;
    dbg_req = 1'b1;
    dbg_addr = 5'd5;
    #1;
    chk("rack_slot_raddr", 32'(rf_raddr), 32'd5);
    exp_q.push_back(reg_bank[5]);
    tick();
    chk_ack("rack_first");
    rst = 1'b1;
    #1;
    chk("rack_ack_cleared", 32'(dbg_ack), 32'd0);
    chk("rack_data_cleared", dbg_data, 32'd0);
    chk("rack_rst_raddr", 32'(rf_raddr), 32'd9);
    tick();
    rst = 1'b0;
    #1;
    chk("rack_reslot_raddr", 32'(rf_raddr), 32'd5);
    exp_q.push_back(reg_bank[5]);
    tick();
    chk_ack("rack_second");
    dbg_req = 1'b0;
    tick();
    tick();

    // Random core traffic without debug: never stalled, address follows core.
    for (int i = 0; i < 1000; i++) begin
      core_req = 1'($urandom_range(0, 1));
      core_addr = 5'($urandom_range(0, 31));
      #1;
      chk("rand_nostall", 32'(core_stall), 32'd0);
      chk("rand_raddr", 32'(rf_raddr), 32'(core_addr));
      tick();
    end

    // Statistics over three starvation runs from a clean reset.
    rst = 1'b1;
    core_req = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    starve_run(5'd1, 5'd30, 0);
    starve_run(5'd6, 5'd11, 0);
    starve_run(5'd8, 5'd25, 0);
`ifdef RF_ARB_STATS_EN
    chk("stat_grants", 32'(stat_dbg_grants), 32'd3);
    chk("stat_stalls", 32'(stat_core_stalls), 32'd3);
`else
    chk("stat_grants", 32'(stat_dbg_grants), 32'd0);
    chk("stat_stalls", 32'(stat_core_stalls), 32'd0);
`endif
    chk("final_qlen", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
